cpu2: RTL and testbench
=======================

Name: cpu2

Overview:
- Execute stage of the 8-bit accumulator-based processor.
- Each instruction is launched by a reset pulse. During reset the block captures opcode, address mode, data/address field and PC from the preceding stage register.
- After reset releases, it resolves the operand (immediate, direct or indirect, via an internal 256x8 data RAM) and executes on the accumulator. It then updates flags, computes the next PC and raises StageComplete.

Parameters:
- MEM_DEPTH, 256, data RAM words (address = 8-bit operand; fixed 256 for 8-bit addressing).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low. Low = hold and capture the stage register; high = run.
- StageRegInstr_out  input  5  opcode.
- StageRegAddrMode_out  input  3  address mode.
- StageRegData_out  input  8  immediate value or memory address.
- StageRegPCtr_out  input  8  PC of this instruction.
- InteruptAdrReg  input  8  interrupt vector.
- ACCout  output  8  accumulator.
- coutRegout  output  1  carry flag.
- zeroRegout  output  1  zero flag.
- overflowRegout  output  1  signed overflow flag.
- NextPctr  output  8  next program counter.
- StageComplete  output  1  instruction finished.

Behaviour:
- Reset is synchronous and active-low. On each clk edge with reset=0:
  - Latch instr, mode, data and pc into internal registers.
  - FSM goes to S_DEC.
  - StageComplete=0; NextPctr=0.
- Reset does not touch ACC, the flags or the RAM. These are architectural state, power-on 0 via register initialisation; the RAM has no reset.
- Reset low mid-operation aborts the instruction; no RAM write occurs unless S_EXE was already reached.
- FSM states:
  - S_DEC: mode 0 → operand=data, go to S_EXE. Mode 1 → ea=data, go to S_RD. Mode 2 → go to S_IND. Modes 3-7 behave as mode 0.
  - S_IND: ea = RAM[data], go to S_RD.
  - S_RD: operand = RAM[ea], go to S_EXE. For STA, skip the read and go to S_EXE.
  - S_EXE: execute the instruction, register results, go to S_DONE.
  - S_DONE: StageComplete=1; hold until the next reset.
- Latency from the first edge with reset=1 to StageComplete=1: 2 edges for mode 0, 3 for mode 1, 4 for mode 2.
- ACC, flags, RAM and NextPctr update on the S_EXE edge.
- Opcodes (op = operand):
  - 00000 NOP.
  - 01000 LDA: ACC=op.
  - 11010 ADD: ACC=ACC+op.
  - 11100 SUB: ACC=ACC-op.
  - 11101 STA: RAM[ea]=ACC. ea=data for modes 0/1, RAM[data] for mode 2.
  - 11110 AND.
  - 10000 OR.
  - 10001 XOR.
  - 10010 NOT: ACC=~ACC.
  - 10011 SHL.
  - 10100 SHR, logical.
  - 00100 JMP.
  - 00101 JZ.
  - 00110 JC.
  - 11111 INT.
  - All other opcodes execute as NOP.
- Flags:
  - ADD: cout = bit 8 of the 9-bit sum. overflow = operands have the same sign and the result sign differs.
  - SUB: cout=1 when there is no borrow (ACC>=op). overflow = operand signs differ and the result sign differs from ACC.
  - SHL/SHR: cout = bit shifted out; overflow=0.
  - Logic ops and NOT: cout=0, overflow=0.
  - zero = (new ACC==0) for every ACC-writing op.
  - LDA updates zero only.
  - STA, NOP and jumps leave all flags unchanged.
- NextPctr:
  - Default pc+1, modulo 256 (255 wraps to 0).
  - JMP: op.
  - JZ: op if zero=1, else pc+1.
  - JC: op if cout=1, else pc+1.
  - INT: InteruptAdrReg.

Optional Feature:
- Macro CPU2_INTERRUPT_EN.
- Defined: opcode 11111 loads NextPctr from InteruptAdrReg. ACC and flags are unchanged.
- Undefined: 11111 is a NOP (NextPctr=pc+1). InteruptAdrReg is ignored.

Test Plan:
- LDA #20 (instr 01000, mode 0, data 20, pc 1), reset pulse → after 2 edges: ACC=20, zero=0, NextPctr=2, StageComplete=1.
- Then ADD #4 (11010) → ACC=24, cout=0, ovf=0. Then SUB #43 (11100) → ACC=237, cout=0 (borrow), zero=0, ovf=0.
- LDA #127; ADD #1 → ACC=128, ovf=1, cout=0. LDA #255; ADD #1 → ACC=0, cout=1, zero=1.
- Indirect path:
  - LDA #8; STA mode 1 data 39 → RAM[39]=8, StageComplete after 3 edges.
  - LDA #39; STA mode 0 data 38 → RAM[38]=39.
  - LDA #12; AND mode 2 data 38 → ACC=8, StageComplete after 4 edges.
- pc=255 NOP → NextPctr=0. JZ #100 with zero=1 → NextPctr=100; with zero=0, pc=5 → 6.
- Reset held low mid-S_RD → no ACC/RAM change, StageComplete=0. Instr 11111 with InteruptAdrReg=0xC1 → NextPctr=0xC1 with macro; pc+1 without.

Source files
------------

// File: rtl/cpu2.sv
// cpu2: execute stage of the 8-bit accumulator processor, with a 256x8 data RAM.
// Build with CPU2_INTERRUPT_EN defined to make opcode 11111 vector NextPctr to InteruptAdrReg.
module cpu2 #(
    parameter int MEM_DEPTH = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] StageRegInstr_out,
    input  logic [2:0] StageRegAddrMode_out,
    input  logic [7:0] StageRegData_out,
    input  logic [7:0] StageRegPCtr_out,
    input  logic [7:0] InteruptAdrReg,
    output logic [7:0] ACCout,
    output logic       coutRegout,
    output logic       zeroRegout,
    output logic       overflowRegout,
    output logic [7:0] NextPctr,
    output logic       StageComplete
);

    typedef enum logic [2:0] {
        S_DEC  = 3'd0,
        S_IND  = 3'd1,
        S_RD   = 3'd2,
        S_EXE  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [4:0] OP_LDA = 5'b01000;
    localparam logic [4:0] OP_ADD = 5'b11010;
    localparam logic [4:0] OP_SUB = 5'b11100;
    localparam logic [4:0] OP_STA = 5'b11101;
    localparam logic [4:0] OP_AND = 5'b11110;
    localparam logic [4:0] OP_OR  = 5'b10000;
    localparam logic [4:0] OP_XOR = 5'b10001;
    localparam logic [4:0] OP_NOT = 5'b10010;
    localparam logic [4:0] OP_SHL = 5'b10011;
    localparam logic [4:0] OP_SHR = 5'b10100;
    localparam logic [4:0] OP_JMP = 5'b00100;
    localparam logic [4:0] OP_JZ  = 5'b00101;
    localparam logic [4:0] OP_JC  = 5'b00110;
`ifdef CPU2_INTERRUPT_EN
    localparam logic [4:0] OP_INT = 5'b11111;
`endif

    // Architectural state powers up to zero and is never touched by reset.
    state_t     state_q   = S_DEC;
    state_t     state_d;
    logic [4:0] instr_q   = '0;
    logic [2:0] mode_q    = '0;
    logic [7:0] data_q    = '0;
    logic [7:0] pc_q      = '0;
    logic [7:0] ea_q      = '0;
    logic [7:0] ea_d;
    logic [7:0] operand_q = '0;
    logic [7:0] operand_d;
    logic [7:0] acc_q     = '0;
    logic [7:0] acc_d;
    logic       cout_q    = 1'b0;
    logic       cout_d;
    logic       zero_q    = 1'b0;
    logic       zero_d;
    logic       ovf_q     = 1'b0;
    logic       ovf_d;
    logic [7:0] npc_q     = '0;
    logic [7:0] npc_d;
    logic       mem_we;
    logic       acc_wr;

    logic [7:0] mem [MEM_DEPTH];

    logic [8:0] sum9;
    logic [8:0] diff9;
    logic [7:0] pc_inc;

    assign sum9   = {1'b0, acc_q} + {1'b0, operand_q};
    assign diff9  = {1'b0, acc_q} - {1'b0, operand_q};
    assign pc_inc = pc_q + 8'd1;

`ifndef CPU2_INTERRUPT_EN
    logic unused_int;
    assign unused_int = ^InteruptAdrReg;
`endif

    function automatic logic add_ovf(input logic signed [7:0] a, input logic signed [7:0] b,
                                     input logic signed [7:0] r);
        return ((a < 0) == (b < 0)) && ((r < 0) != (a < 0));
    endfunction

    function automatic logic sub_ovf(input logic signed [7:0] a, input logic signed [7:0] b,
                                     input logic signed [7:0] r);
        return ((a < 0) != (b < 0)) && ((r < 0) != (a < 0));
    endfunction

    always_comb begin
        state_d   = state_q;
        ea_d      = ea_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        cout_d    = cout_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        npc_d     = npc_q;
        mem_we    = 1'b0;
        acc_wr    = 1'b0;
        case (state_q)
            S_DEC: begin
                ea_d      = data_q;
                operand_d = data_q;
                case (mode_q)
                    3'd1:    state_d = S_RD;
                    3'd2:    state_d = S_IND;
                    default: state_d = S_EXE;
                endcase
            end
            S_IND: begin
                ea_d    = mem[data_q];
                state_d = S_RD;
            end
            S_RD: begin
                if (instr_q != OP_STA) begin
                    operand_d = mem[ea_q];
                end
                state_d = S_EXE;
            end
            S_EXE: begin
                state_d = S_DONE;
                npc_d   = pc_inc;
                case (instr_q)
                    OP_LDA: begin
                        acc_d  = operand_q;
                        acc_wr = 1'b1;
                    end
                    OP_ADD: begin
                        acc_d  = sum9[7:0];
                        cout_d = sum9[8];
                        ovf_d  = add_ovf(acc_q, operand_q, sum9[7:0]);
                        acc_wr = 1'b1;
                    end
                    OP_SUB: begin
                        acc_d  = diff9[7:0];
                        cout_d = ~diff9[8];
                        ovf_d  = sub_ovf(acc_q, operand_q, diff9[7:0]);
                        acc_wr = 1'b1;
                    end
                    OP_STA: mem_we = 1'b1;
                    OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                        case (instr_q)
                            OP_AND:  acc_d = acc_q & operand_q;
                            OP_OR:   acc_d = acc_q | operand_q;
                            OP_XOR:  acc_d = acc_q ^ operand_q;
                            default: acc_d = ~acc_q;
                        endcase
                        cout_d = 1'b0;
                        ovf_d  = 1'b0;
                        acc_wr = 1'b1;
                    end
                    OP_SHL: begin
                        acc_d  = {acc_q[6:0], 1'b0};
                        cout_d = acc_q[7];
                        ovf_d  = 1'b0;
                        acc_wr = 1'b1;
                    end
                    OP_SHR: begin
                        acc_d  = {1'b0, acc_q[7:1]};
                        cout_d = acc_q[0];
                        ovf_d  = 1'b0;
                        acc_wr = 1'b1;
                    end
                    OP_JMP: npc_d = operand_q;
                    OP_JZ:  npc_d = zero_q ? operand_q : pc_inc;
                    OP_JC:  npc_d = cout_q ? operand_q : pc_inc;
`ifdef CPU2_INTERRUPT_EN
                    OP_INT: npc_d = InteruptAdrReg;
`else
`endif
                    default: ;
                endcase
                if (acc_wr) begin
                    zero_d = (acc_d == 8'd0);
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_DEC;
        endcase
    end

    // Reset low captures the stage register and restarts decode; data state is left alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_q <= StageRegInstr_out;
            mode_q  <= StageRegAddrMode_out;
            data_q  <= StageRegData_out;
            pc_q    <= StageRegPCtr_out;
            state_q <= S_DEC;
            npc_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            ea_q      <= ea_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            cout_q    <= cout_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            npc_q     <= npc_d;
            if (mem_we) begin
                mem[ea_q] <= acc_q;
            end
        end
    end

    assign ACCout         = acc_q;
    assign coutRegout     = cout_q;
    assign zeroRegout     = zero_q;
    assign overflowRegout = ovf_q;
    assign NextPctr       = npc_q;
    assign StageComplete  = (state_q == S_DONE);

endmodule

// File: tb/tb_cpu2.sv
// Directed self-checking bench for cpu2: hand-computed results for each instruction launch.
module tb_cpu2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] instr = '0;
    logic [2:0] mode = '0;
    logic [7:0] data = '0;
    logic [7:0] pc = '0;
    logic [7:0] int_adr = '0;
    logic [7:0] acc;
    logic       cout;
    logic       zero;
    logic       ovf;
    logic [7:0] npc;
    logic       done;

    int checks = 0;
    int errors = 0;

    cpu2 dut (
        .clk                 (clk),
        .reset               (reset),
        .StageRegInstr_out   (instr),
        .StageRegAddrMode_out(mode),
        .StageRegData_out    (data),
        .StageRegPCtr_out    (pc),
        .InteruptAdrReg      (int_adr),
        .ACCout              (acc),
        .coutRegout          (cout),
        .zeroRegout          (zero),
        .overflowRegout      (ovf),
        .NextPctr            (npc),
        .StageComplete       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic c, input logic z, input logic v);
        chk({tag, ".cout"}, {7'd0, cout}, {7'd0, c});
        chk({tag, ".zero"}, {7'd0, zero}, {7'd0, z});
        chk({tag, ".ovf"},  {7'd0, ovf},  {7'd0, v});
    endtask

    // Pulse reset for one edge with the stage register driven, then release.
    task automatic start(input logic [4:0] i, input logic [2:0] m, input logic [7:0] d,
                         input logic [7:0] p);
        @(negedge clk);
        instr = i;
        mode  = m;
        data  = d;
        pc    = p;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Launch and confirm StageComplete rises exactly after the given number of edges.
    task automatic exec(input string tag, input logic [4:0] i, input logic [2:0] m,
                        input logic [7:0] d, input logic [7:0] p, input int edges);
        start(i, m, d, p);
        repeat (edges - 1) @(negedge clk);
        chk({tag, ".early_done"}, {7'd0, done}, 8'd0);
        @(negedge clk);
        chk({tag, ".done"}, {7'd0, done}, 8'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset.acc", acc, 8'd0);
        chk_flags("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.npc", npc, 8'd0);
        chk("reset.done", {7'd0, done}, 8'd0);

        exec("lda20", 5'b01000, 3'd0, 8'd20, 8'd1, 2);
        chk("lda20.acc", acc, 8'd20);
        chk("lda20.zero", {7'd0, zero}, 8'd0);
        chk("lda20.npc", npc, 8'd2);

        exec("add4", 5'b11010, 3'd0, 8'd4, 8'd2, 2);
        chk("add4.acc", acc, 8'd24);
        chk_flags("add4", 1'b0, 1'b0, 1'b0);
        chk("add4.npc", npc, 8'd3);

        exec("sub43", 5'b11100, 3'd0, 8'd43, 8'd3, 2);
        chk("sub43.acc", acc, 8'd237);
        chk_flags("sub43", 1'b0, 1'b0, 1'b0);

        exec("lda127", 5'b01000, 3'd0, 8'd127, 8'd4, 2);
        exec("add_ovf", 5'b11010, 3'd0, 8'd1, 8'd5, 2);
        chk("add_ovf.acc", acc, 8'd128);
        chk_flags("add_ovf", 1'b0, 1'b0, 1'b1);

        exec("lda255", 5'b01000, 3'd0, 8'd255, 8'd6, 2);
        exec("add_wrap", 5'b11010, 3'd0, 8'd1, 8'd7, 2);
        chk("add_wrap.acc", acc, 8'd0);
        chk_flags("add_wrap", 1'b1, 1'b1, 1'b0);

        exec("lda8", 5'b01000, 3'd0, 8'd8, 8'd10, 2);
        chk_flags("lda8", 1'b1, 1'b0, 1'b0);
        exec("sta_dir", 5'b11101, 3'd1, 8'd39, 8'd11, 3);
        chk("sta_dir.acc", acc, 8'd8);
        chk("sta_dir.npc", npc, 8'd12);
        chk_flags("sta_dir", 1'b1, 1'b0, 1'b0);

        exec("lda39", 5'b01000, 3'd0, 8'd39, 8'd12, 2);
        exec("sta_imm", 5'b11101, 3'd0, 8'd38, 8'd13, 2);
        exec("lda12", 5'b01000, 3'd0, 8'd12, 8'd14, 2);
        exec("and_ind", 5'b11110, 3'd2, 8'd38, 8'd15, 4);
        chk("and_ind.acc", acc, 8'd8);
        chk_flags("and_ind", 1'b0, 1'b0, 1'b0);

        exec("lda_dir", 5'b01000, 3'd1, 8'd38, 8'd16, 3);
        chk("lda_dir.acc", acc, 8'd39);

        exec("nop255", 5'b00000, 3'd0, 8'd0, 8'd255, 2);
        chk("nop255.npc", npc, 8'd0);
        chk("nop255.acc", acc, 8'd39);

        exec("lda0", 5'b01000, 3'd0, 8'd0, 8'd19, 2);
        exec("jz_taken", 5'b00101, 3'd0, 8'd100, 8'd20, 2);
        chk("jz_taken.npc", npc, 8'd100);
        exec("lda1", 5'b01000, 3'd0, 8'd1, 8'd21, 2);
        exec("jz_not", 5'b00101, 3'd0, 8'd100, 8'd5, 2);
        chk("jz_not.npc", npc, 8'd6);

        exec("shl", 5'b10011, 3'd0, 8'd0, 8'd22, 2);
        chk("shl.acc", acc, 8'd2);
        chk_flags("shl", 1'b0, 1'b0, 1'b0);
        exec("jmp", 5'b00100, 3'd0, 8'd77, 8'd23, 2);
        chk("jmp.npc", npc, 8'd77);

        exec("lda50", 5'b01000, 3'd0, 8'd50, 8'd30, 2);
        start(5'b11010, 3'd1, 8'd39, 8'd31);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_add.acc", acc, 8'd50);
        chk("abort_add.done", {7'd0, done}, 8'd0);
        chk("abort_add.npc", npc, 8'd0);

        start(5'b11101, 3'd2, 8'd38, 8'd32);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_sta.done", {7'd0, done}, 8'd0);
        exec("ram_kept", 5'b01000, 3'd1, 8'd39, 8'd33, 3);
        chk("ram_kept.acc", acc, 8'd8);

        int_adr = 8'hC1;
        exec("int", 5'b11111, 3'd0, 8'd0, 8'd40, 2);
`ifdef CPU2_INTERRUPT_EN
        chk("int.npc", npc, 8'hC1);
`else
        chk("int.npc", npc, 8'd41);
`endif
        chk("int.acc", acc, 8'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
